me_control: RTL and testbench

Sequencing controller for the full-search motion estimator. It sits directly upstream of `Comparator` and the 16-PE array. It steps the 16×16 reference block over all 256 candidate positions (vectorX, vectorY ∈ 0..15) in a 31×31 search window, and generates the reference and search memory addresses and the per-PE accumulator clears. It also drives the `CompStart`/`PEready`/`vectorX`/`vectorY` stream that `Comparator` consumes.

---
 rtl/me_pkg.sv | 19 +
 rtl/me_ready_decoder.sv | 40 ++++
 rtl/me_control.sv | 106 ++++++++++
 tb/tb_me_control.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared constants and state type for the motion-estimator sequencer.
// Imported by me_control and me_ready_decoder.
package me_pkg;

  localparam int ME_NUM_PE = 16;
  localparam int ME_BLK    = 16;
  localparam int ME_SW     = 31;

  localparam logic [12:0] ME_LAST_COUNT = 13'd4111;
  localparam logic [12:0] ME_RUN_LAST   = 13'd4095;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } me_ctrl_state_t;

endpackage

// File: rtl/me_ready_decoder.sv
// Decodes state/count into PE clears, PE-ready strobes and vectors.
// In: state, count. Out: pe_ready, vector_x/y, new_dist, comp_start.
module me_ready_decoder
  import me_pkg::*;
(
  input  me_ctrl_state_t         state,
  input  logic [12:0]            count,
  output logic [ME_NUM_PE-1:0]   pe_ready,
  output logic [3:0]             vector_x,
  output logic [3:0]             vector_y,
  output logic [ME_NUM_PE-1:0]   new_dist,
  output logic                   comp_start
);

  logic active;
  logic past_first;
  logic row0;

  always_comb begin
    active     = (state == ST_RUN) || (state == ST_DRAIN);
    past_first = |count[12:8];
    row0       = (count[7:4] == 4'd0);
    pe_ready   = '0;
    vector_x   = '0;
    vector_y   = '0;
    new_dist   = '0;
    comp_start = (state == ST_DONE) || (active && past_first);
    // PE k finishes a candidate one pass after it started it,
    // so the reported Y is one behind the current pass.
    if (active && past_first && row0) begin
      pe_ready[count[3:0]] = 1'b1;
      vector_x             = count[3:0];
      vector_y             = count[11:8] - 4'd1;
    end
    if ((state == ST_RUN) && row0) begin
      new_dist[count[3:0]] = 1'b1;
    end
  end

endmodule

// File: rtl/me_control.sv
// Full-search ME sequencer: steps 256 candidates, drives memory
// addresses, PE clears and Comparator stream. Optional ME_CTRL_ABORT_EN.
module me_control
  import me_pkg::*;
#(
  parameter int NUM_PE = ME_NUM_PE,
  parameter int BLK    = ME_BLK
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
`ifdef ME_CTRL_ABORT_EN
  input  logic                          abort,
`endif
  output logic                          busy,
  output logic                          done,
  output logic [2*$clog2(BLK)-1:0]      addrR,
  output logic [2*$clog2(ME_SW)-1:0]    addrS1,
  output logic [2*$clog2(ME_SW)-1:0]    addrS2,
  output logic [NUM_PE-1:0]             newDist,
  output logic                          CompStart,
  output logic [NUM_PE-1:0]             PEready,
  output logic [3:0]                    vectorX,
  output logic [3:0]                    vectorY
);

  me_ctrl_state_t state_q, state_d;
  logic [12:0]    count_q, count_d;
  logic [11:0]    addr_cnt;
  logic [4:0]     row;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        count_d = count_q + 13'd1;
        if (count_q == ME_RUN_LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        count_d = count_q + 13'd1;
        if (count_q == ME_LAST_COUNT) state_d = ST_DONE;
      end
      ST_DONE: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase
`ifdef ME_CTRL_ABORT_EN
    if (abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN))) begin
      count_d = '0;
      state_d = ST_IDLE;
    end
`endif
  end

  assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);

  // DRAIN keeps presenting the last RUN address.
  always_comb begin
    unique case (1'b1)
      state_q == ST_RUN:   addr_cnt = count_q[11:0];
      state_q == ST_DRAIN: addr_cnt = ME_RUN_LAST[11:0];
      default:             addr_cnt = '0;
    endcase
    row    = {1'b0, addr_cnt[11:8]} + {1'b0, addr_cnt[7:4]};
    addrR  = '0;
    addrS1 = '0;
    addrS2 = '0;
    if (busy) begin
      addrR  = addr_cnt[7:0];
      addrS1 = {row, 1'b0, addr_cnt[3:0]};
      addrS2 = {row, 1'b1, addr_cnt[3:0]};
    end
  end

  me_ready_decoder u_dec (
    .state      (state_q),
    .count      (count_q),
    .pe_ready   (PEready),
    .vector_x   (vectorX),
    .vector_y   (vectorY),
    .new_dist   (newDist),
    .comp_start (CompStart)
  );

endmodule

// File: tb/tb_me_control.sv
// Scoreboard bench for me_control: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_me_control;

  logic       clock;
  logic       reset_n;
  logic       start;
`ifdef ME_CTRL_ABORT_EN
  logic       abort;
`endif
  logic       busy, done, CompStart;
  logic [7:0] addrR;
  logic [9:0] addrS1, addrS2;
  logic [15:0] newDist, PEready;
  logic [3:0] vectorX, vectorY;
  logic [70:0] outs;

  me_control dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
`ifdef ME_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .addrR     (addrR),
    .addrS1    (addrS1),
    .addrS2    (addrS2),
    .newDist   (newDist),
    .CompStart (CompStart),
    .PEready   (PEready),
    .vectorX   (vectorX),
    .vectorY   (vectorY)
  );

  assign outs = {busy, done, CompStart, PEready, newDist,
                 vectorX, vectorY, addrR, addrS1, addrS2};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [15:0] pe;
    logic [3:0] vx;
    logic [3:0] vy;
  } pe_t;

  typedef struct {
    int         at;
    bit         chk_addr;
    logic       busy;
    logic       done;
    logic       comp;
    logic [15:0] pe;
    logic [15:0] nd;
    logic [7:0] ar;
    logic [9:0] s1;
    logic [9:0] s2;
    logic [3:0] vx;
    logic [3:0] vy;
  } probe_t;

  pe_t    pe_q[$];
  int     done_q[$];
  probe_t pr_q[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
  endtask

  task automatic probe(input int at, input bit ca, input logic b,
                       input logic d, input logic c,
                       input logic [15:0] pe, input logic [15:0] nd,
                       input logic [7:0] ar, input logic [9:0] s1,
                       input logic [9:0] s2, input logic [3:0] vx,
                       input logic [3:0] vy);
    probe_t p;
    p.at = at; p.chk_addr = ca; p.busy = b; p.done = d; p.comp = c;
    p.pe = pe; p.nd = nd; p.ar = ar; p.s1 = s1; p.s2 = s2;
    p.vx = vx; p.vy = vy;
    pr_q.push_back(p);
  endtask

  task automatic zero_probe(input int at);
    probe(at, 1, 0, 0, 0, 16'h0, 16'h0, 8'h0, 10'd0, 10'd0, 4'd0, 4'd0);
  endtask

  task automatic flush();
    pe_q.delete();
    done_q.delete();
    pr_q.delete();
  endtask

  // Expected behaviour of one complete search whose count=0 cycle is t0.
  task automatic push_run(input int t0);
    pe_t e;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        e.at = t0 + 256 * (y + 1) + x;
        e.pe = 16'h1 << x;
        e.vx = 4'(x);
        e.vy = 4'(y);
        pe_q.push_back(e);
      end
    end
    done_q.push_back(t0 + 4112);
    probe(t0 + 0,    1, 1, 0, 0, 16'h0000, 16'h0001, 8'h00, 10'd0,   10'd16,  4'd0, 4'd0);
    probe(t0 + 1,    1, 1, 0, 0, 16'h0000, 16'h0002, 8'h01, 10'd1,   10'd17,  4'd0, 4'd0);
    probe(t0 + 15,   1, 1, 0, 0, 16'h0000, 16'h8000, 8'h0f, 10'd15,  10'd31,  4'd0, 4'd0);
    probe(t0 + 255,  1, 1, 0, 0, 16'h0000, 16'h0000, 8'hff, 10'd495, 10'd511, 4'd0, 4'd0);
    probe(t0 + 256,  1, 1, 0, 1, 16'h0001, 16'h0001, 8'h00, 10'd32,  10'd48,  4'd0, 4'd0);
    probe(t0 + 291,  1, 1, 0, 1, 16'h0000, 16'h0000, 8'h23, 10'd99,  10'd115, 4'd0, 4'd0);
    probe(t0 + 4100, 1, 1, 0, 1, 16'h0010, 16'h0000, 8'hff, 10'd975, 10'd991, 4'd4, 4'd15);
    probe(t0 + 4112, 0, 0, 1, 1, 16'h0000, 16'h0000, 8'h00, 10'd0,   10'd0,   4'd0, 4'd0);
    zero_probe(t0 + 4113);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic do_start(output int t0);
    start = 1'b1;
    t0 = cyc + 1;
    push_run(t0);
    @(negedge clock);
    start = 1'b0;
  endtask

  pe_t    pe_e;
  int     done_e;
  probe_t pr_e;

  always @(negedge clock) begin
    if (PEready !== 16'h0) begin
      if (pe_q.size() == 0) chk("pe_unexpected", PEready, 16'h0);
      else begin
        pe_e = pe_q.pop_front();
        chk("pe_time", cyc, pe_e.at);
        chk("pe_val", {PEready, vectorX, vectorY},
            {pe_e.pe, pe_e.vx, pe_e.vy});
      end
    end
    if (done !== 1'b0) begin
      if (done_q.size() == 0) chk("done_unexpected", done, 1'b0);
      else begin
        done_e = done_q.pop_front();
        chk("done_time", cyc, done_e);
      end
    end
    while (pr_q.size() > 0 && pr_q[0].at <= cyc) begin
      pr_e = pr_q.pop_front();
      chk("probe_time", cyc, pr_e.at);
      chk("probe_ctl",
          {busy, done, CompStart, PEready, newDist, vectorX, vectorY},
          {pr_e.busy, pr_e.done, pr_e.comp, pr_e.pe, pr_e.nd,
           pr_e.vx, pr_e.vy});
      if (pr_e.chk_addr)
        chk("probe_addr", {addrR, addrS1, addrS2},
            {pr_e.ar, pr_e.s1, pr_e.s2});
    end
  end

  int t0;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
`ifdef ME_CTRL_ABORT_EN
    abort   = 1'b0;
`endif
    #1 chk("reset_outs", outs, 71'h0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) zero_probe(cyc + i);
    wait_cyc(cyc + 11);

    // Full run with an ignored start pulse mid-search.
    do_start(t0);
    wait_cyc(t0 + 1000);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_cyc(t0 + 4120);

    // Asynchronous reset mid-run.
    do_start(t0);
    wait_cyc(t0 + 2000);
    #2 reset_n = 1'b0;
    #1 chk("reset_async", outs, 71'h0);
    flush();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    zero_probe(cyc + 1);
    zero_probe(cyc + 5);
    wait_cyc(cyc + 6);

`ifdef ME_CTRL_ABORT_EN
    do_start(t0);
    wait_cyc(t0 + 1000);
    abort = 1'b1;
    flush();
    zero_probe(cyc + 1);
    zero_probe(cyc + 3);
    @(negedge clock);
    abort = 1'b0;
    wait_cyc(cyc + 4);
`endif

    // Fresh start after reset/abort runs to completion from count 0.
    do_start(t0);
    wait_cyc(t0 + 4120);

    chk("pe_q_drained", pe_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    chk("probe_q_drained", pr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
